uart_prog_loader: RTL and testbench

UART-fed program loader that drives the core's program-load port (prog_loadaddr/prog_loaddata/prog_imem_we/prog_dmem_we) while the pipeline is held in reset. It receives an 8N1 byte stream on rxd and parses an 8-byte header followed by an instruction image and a data image. It assembles the instruction image into 128-bit imem lines and the data image into 32-bit dmem words. It asserts done once both images have been written.

---
 rtl/uart_prog_loader_pkg.sv | 23 ++
 rtl/uart_prog_loader_rx.sv | 114 +++++++++++
 rtl/uart_prog_loader.sv | 182 ++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared encodings and framing constants for the UART program loader.
// Imported by the receiver and the loader top.
package uart_prog_loader_pkg;

    typedef enum logic [1:0] {
        LD_HDR,
        LD_IMEM,
        LD_DMEM,
        LD_FIN
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int HDR_BYTES  = 8;
    localparam int LINE_BYTES = 16;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle
// byte strobe on a good stop bit and a one-cycle error strobe on a bad one.
module uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_x,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rxs;

    assign rxs = sync_q[1];

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rxd};
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rxs) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Program loader: parses header, packs imem lines and dmem words from
// the UART byte stream and strobes them onto the core load port.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_LEN     = 32
) (
    input  logic                clk,
    input  logic                reset_x,
    input  logic                rxd,
    output logic [ADDR_LEN-1:0] addr,
    output logic [127:0]        data,
    output logic                we_128,
    output logic                we_32,
    output logic                done,
    output logic                err
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset_x (reset_x),
        .rxd     (rxd),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    ld_state_e           state_q, state_d;
    logic [2:0]          hcnt_q, hcnt_d;
    logic [31:0]         icount_q, icount_d;
    logic [31:0]         dcount_q, dcount_d;
    logic [31:0]         bcnt_q, bcnt_d;
    logic [127:0]        buf_q, buf_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [127:0]        data_q, data_d;
    logic                we128_q, we128_d;
    logic                we32_q, we32_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [3:0]   bidx;
    logic [6:0]   bpos;
    logic [127:0] buf_ins;
    logic [31:0]  cur_count;
    logic         last;

    // Byte b of a line lands in word b/4 (word 0 at the top), little-endian
    // inside the word; dmem uses the same placement with only word 0.
    always_comb begin
        bidx = (state_q == LD_IMEM) ? bcnt_q[3:0]
                                    : {2'b00, bcnt_q[1:0]};
        bpos = 7'd96 - {bidx[3:2], 5'b0} + {2'b00, bidx[1:0], 3'b0};
        buf_ins = buf_q;
        buf_ins[bpos +: 8] = rx_data;
        cur_count = (state_q == LD_IMEM) ? icount_q : dcount_q;
        last = (bcnt_q + 32'd1 == cur_count);
    end

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        icount_d = icount_q;
        dcount_d = dcount_q;
        bcnt_d   = bcnt_q;
        buf_d    = buf_q;
        data_d   = data_q;
        we128_d  = 1'b0;
        we32_d   = 1'b0;
        done_d   = done_q | (state_q == LD_FIN);
        err_d    = err_q | rx_ferr;

        addr_d = addr_q;
        if (we128_q) begin
            addr_d = (state_q == LD_IMEM) ? addr_q + ADDR_LEN'(LINE_BYTES)
                                          : '0;
        end else if (we32_q) begin
            addr_d = addr_q + ADDR_LEN'(WORD_BYTES);
        end

        unique case (state_q)
            LD_HDR: begin
                if (rx_valid) begin
                    if (hcnt_q[2]) begin
                        dcount_d[{hcnt_q[1:0], 3'b0} +: 8] = rx_data;
                    end else begin
                        icount_d[{hcnt_q[1:0], 3'b0} +: 8] = rx_data;
                    end
                    hcnt_d = hcnt_q + 3'd1;
                    bcnt_d = '0;
                    buf_d  = '0;
                    if (hcnt_q == 3'(HDR_BYTES - 1)) begin
                        if (icount_d != 32'd0) begin
                            state_d = LD_IMEM;
                        end else if (dcount_d != 32'd0) begin
                            state_d = LD_DMEM;
                        end else begin
                            state_d = LD_FIN;
                        end
                    end
                end
            end
            LD_IMEM: begin
                if (rx_valid) begin
                    bcnt_d = bcnt_q + 32'd1;
                    buf_d  = buf_ins;
                    if (bidx == 4'd15 || last) begin
                        we128_d = 1'b1;
                        data_d  = buf_ins;
                        buf_d   = '0;
                    end
                    if (last) begin
                        bcnt_d  = '0;
                        state_d = (dcount_q != 32'd0) ? LD_DMEM : LD_FIN;
                    end
                end
            end
            LD_DMEM: begin
                if (rx_valid) begin
                    bcnt_d = bcnt_q + 32'd1;
                    buf_d  = buf_ins;
                    if (bidx[1:0] == 2'd3 || last) begin
                        we32_d = 1'b1;
                        data_d = {buf_ins[127:96], 96'b0};
                        buf_d  = '0;
                    end
                    if (last) begin
                        state_d = LD_FIN;
                    end
                end
            end
            LD_FIN: begin
                done_d = 1'b1;
            end
            default: state_d = LD_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q  <= LD_HDR;
            hcnt_q   <= '0;
            icount_q <= '0;
            dcount_q <= '0;
            bcnt_q   <= '0;
            buf_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we128_q  <= 1'b0;
            we32_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            icount_q <= icount_d;
            dcount_q <= dcount_d;
            bcnt_q   <= bcnt_d;
            buf_q    <= buf_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we128_q  <= we128_d;
            we32_q   <= we32_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign addr   = addr_q;
    assign data   = data_q;
    assign we_128 = we128_q;
    assign we_32  = we32_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader: serializes load streams onto rxd
// and compares captured write strobes with a byte-level image model.
module tb_uart_prog_loader;

    localparam int CPB = 8;

    logic         clk = 1'b0;
    logic         reset_x = 1'b0;
    logic         rxd = 1'b1;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         we_128;
    logic         we_32;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_LEN    (32)
    ) dut (
        .clk    (clk),
        .reset_x(reset_x),
        .rxd    (rxd),
        .addr   (addr),
        .data   (data),
        .we_128 (we_128),
        .we_32  (we_32),
        .done   (done),
        .err    (err)
    );

    typedef struct {
        logic         imem;
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_x && (we_128 || we_32)) begin
            wr_t w;
            w.imem = we_128;
            w.addr = addr;
            w.data = data;
            obs_q.push_back(w);
        end
    end

    task automatic push_exp(input logic imem, input logic [31:0] a,
                            input logic [127:0] d);
        wr_t w;
        w.imem = imem;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Reference: imem line l holds words k=0..3 from the top, each word
    // little-endian from bytes 16l+4k..; dmem word w sits in [127:96].
    task automatic build_exp(input int ic, input int dc,
                             input logic [7:0] img[$],
                             input logic [7:0] dimg[$]);
        for (int l = 0; l * 16 < ic; l++) begin
            logic [127:0] d;
            d = '0;
            for (int k = 0; k < 4; k++) begin
                logic [31:0] wd;
                wd = '0;
                for (int j = 0; j < 4; j++) begin
                    int i;
                    i = 16 * l + 4 * k + j;
                    if (i < ic) wd = wd | (32'(img[i]) << (8 * j));
                end
                d[127 - 32 * k -: 32] = wd;
            end
            push_exp(1'b1, 32'(16 * l), d);
        end
        for (int w = 0; w * 4 < dc; w++) begin
            logic [31:0] wd;
            wd = '0;
            for (int j = 0; j < 4; j++) begin
                int i;
                i = 4 * w + j;
                if (i < dc) wd = wd | (32'(dimg[i]) << (8 * j));
            end
            push_exp(1'b0, 32'(4 * w), {wd, 96'b0});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (stop ? 2 : 2 * CPB) @(negedge clk);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int bad_at);
        for (int i = 0; i < s.size(); i++) begin
            if (i == bad_at) send_byte(8'($urandom), 1'b0);
            send_byte(s[i], 1'b1);
        end
    endtask

    function automatic void add_hdr(inout logic [7:0] s[$],
                                    input logic [31:0] ic,
                                    input logic [31:0] dc);
        for (int j = 0; j < 4; j++) s.push_back(ic[8 * j +: 8]);
        for (int j = 0; j < 4; j++) s.push_back(dc[8 * j +: 8]);
    endfunction

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, ".done"}, 128'(done), 128'd1);
    endtask

    task automatic compare(input string name);
        int n;
        check({name, ".nwr"}, 128'(obs_q.size()), 128'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.kind%0d", name, i),
                  128'(obs_q[i].imem), 128'(exp_q[i].imem));
            check($sformatf("%s.addr%0d", name, i),
                  128'(obs_q[i].addr), 128'(exp_q[i].addr));
            check($sformatf("%s.data%0d", name, i),
                  obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_load(input string name, input int ic, input int dc,
                            input logic [7:0] img[$],
                            input logic [7:0] dimg[$],
                            input int bad_at, input bit use_model,
                            input logic exp_err);
        logic [7:0] s[$];
        add_hdr(s, 32'(ic), 32'(dc));
        foreach (img[i]) s.push_back(img[i]);
        foreach (dimg[i]) s.push_back(dimg[i]);
        if (use_model) build_exp(ic, dc, img, dimg);
        send_stream(s, bad_at);
        wait_done(name);
        repeat (4) @(negedge clk);
        check({name, ".err"}, 128'(err), 128'(exp_err));
        compare(name);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_x = 1'b0;
        repeat (2) @(negedge clk);
        reset_x = 1'b1;
        obs_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, ".addr"}, 128'(addr), 128'd0);
        check({name, ".data"}, data, 128'd0);
        check({name, ".we128"}, 128'(we_128), 128'd0);
        check({name, ".we32"}, 128'(we_32), 128'd0);
        check({name, ".done"}, 128'(done), 128'd0);
        check({name, ".err"}, 128'(err), 128'd0);
    endtask

    task automatic rand_img(output logic [7:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img[$];
        logic [7:0] dimg[$];
        logic [7:0] s[$];

        repeat (3) @(negedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        reset_x = 1'b1;
        repeat (2) @(negedge clk);

        // Full load with literal expectations
        img.delete();
        dimg.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'(i));
        for (int i = 0; i < 8; i++) dimg.push_back(8'(16 + i));
        push_exp(1'b1, 32'd0,
                 128'h03020100_07060504_0B0A0908_0F0E0D0C);
        push_exp(1'b0, 32'd0, {32'h13121110, 96'b0});
        push_exp(1'b0, 32'd4, {32'h17161514, 96'b0});
        run_load("full", 16, 8, img, dimg, -1, 1'b0, 1'b0);

        // Partial imem line, no dmem
        pulse_reset();
        img.delete();
        dimg.delete();
        for (int i = 0; i < 6; i++) img.push_back(8'hAA + 8'(i));
        push_exp(1'b1, 32'd0,
                 128'hADACABAA_0000AFAE_00000000_00000000);
        run_load("part", 6, 0, img, dimg, -1, 1'b0, 1'b0);

        // Empty images
        pulse_reset();
        s.delete();
        add_hdr(s, 32'd0, 32'd0);
        send_stream(s, -1);
        repeat (4) @(negedge clk);
        check("empty.done", 128'(done), 128'd1);
        check("empty.nwr", 128'(obs_q.size()), 128'd0);

        // Framing error inside the header
        pulse_reset();
        rand_img(img, 4);
        rand_img(dimg, 5);
        run_load("ferr", 4, 5, img, dimg, 2, 1'b1, 1'b1);

        // Glitch in idle, then reset mid-line
        pulse_reset();
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch.err", 128'(err), 128'd0);
        rand_img(img, 21);
        s.delete();
        add_hdr(s, 32'd32, 32'd0);
        foreach (img[i]) s.push_back(img[i]);
        send_stream(s, -1);
        repeat (4) @(negedge clk);
        dimg.delete();
        build_exp(16, 0, img, dimg);
        compare("glitch");
        check("glitch.addr", 128'(addr), 128'd16);
        check("glitch.done", 128'(done), 128'd0);
        @(posedge clk);
        #2;
        reset_x = 1'b0;
        #1;
        check_zero("async");
        @(negedge clk);
        reset_x = 1'b1;
        obs_q.delete();
        repeat (2) @(negedge clk);
        rand_img(img, 20);
        rand_img(dimg, 7);
        run_load("fresh", 20, 7, img, dimg, -1, 1'b1, 1'b0);

        // Random loads
        for (int t = 0; t < 4; t++) begin
            int ic;
            int dc;
            ic = int'($urandom_range(0, 36));
            dc = int'($urandom_range(0, 12));
            pulse_reset();
            rand_img(img, ic);
            rand_img(dimg, dc);
            run_load($sformatf("rnd%0d", t), ic, dc, img, dimg,
                     -1, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
